display_scan_ctrl: RTL and testbench
====================================

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 25000, giving DRIVE clocks per digit; legal 2..65535.
REQ-002 The block SHALL have parameter BLANK_CYCLES, default 16, giving all-anodes-off clocks between digits; legal 1..255.
REQ-003 The block SHALL have port clk, input, 1 bit: single system clock, all state on rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-005 The block SHALL have port enable, input, 1 bit: 1 = scan display, 0 = all digits dark.
REQ-006 The block SHALL have port load_req, input, 1 bit: new display value offered on load_data/load_dp.
REQ-007 The block SHALL have port load_data, input, 16 bits: four hex nibbles, [3:0] = digit 0 (rightmost).
REQ-008 The block SHALL have port load_dp, input, 4 bits: decimal point per digit, 1 = lit.
REQ-009 The block SHALL have port load_ack, output, 1 bit: one-cycle pulse, offered value accepted.
REQ-010 The block SHALL have port an, output, 4 bits: active-low anode enables, an[i] = digit i.
REQ-011 The block SHALL have port seg, output, 7 bits: active-low cathodes, order {g,f,e,d,c,b,a}.
REQ-012 The block SHALL have port dp, output, 1 bit: active-low decimal point cathode.
REQ-013 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse at end of digit 3 DRIVE.

Function
REQ-014 The FSM SHALL have states IDLE, BLANK and DRIVE, plus 2-bit digit index idx.
REQ-015 In IDLE: an=4'b1111, seg=7'h7F, dp=1; enable=1 -> BLANK with idx=0.
REQ-016 In BLANK: an=4'b1111, seg=7'h7F, dp=1 for exactly BLANK_CYCLES clocks, then -> DRIVE.
REQ-017 In DRIVE: an[idx]=0, other anodes 1; seg = decode of display nibble idx; dp = ~display_dp[idx].
REQ-018 The 16-bit prescaler SHALL count only in DRIVE and wrap at TICK_DIV-1; the wrap cycle is the tick; the prescaler clears on leaving DRIVE.
REQ-019 On tick: idx <= idx+1 mod 4, -> BLANK; when idx=3, frame_done=1 for that cycle.
REQ-020 enable=0 in any state SHALL force IDLE next clock, with idx, prescaler and blank counter cleared.
REQ-021 Decode SHALL be: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex).
REQ-022 If load_req=1 and no shadow pending, shadow <= load_data/load_dp, pending <= 1, load_ack=1 that cycle.
REQ-023 While pending=1, load_ack SHALL stay 0 and load_req SHALL be held (stall).
REQ-024 Shadow SHALL copy to the display register on the frame_done cycle, or on the next clock when in IDLE; pending then clears.
REQ-025 A simultaneous transfer and new load_req SHALL perform the transfer only; the request is accepted the following cycle.
REQ-026 The display register SHALL never change mid-frame while enable=1 (no tearing).

Reset
REQ-027 While reset=0: state=IDLE, idx=0, counters=0, display=16'h0000, display_dp=0, pending=0, an=4'hF, seg=7'h7F, dp=1, load_ack=0, frame_done=0.
REQ-028 Reset assertion mid-DRIVE SHALL darken all anodes asynchronously, without waiting for a clock.

Configuration
REQ-029 With LEADING_ZERO_BLANK_EN defined, digit i (i=3,2,1) SHALL output seg=7'h7F in DRIVE when nibble i and all higher nibbles are 0; digit 0 is never blanked; an and dp timing are unchanged.
REQ-030 Without LEADING_ZERO_BLANK_EN, every digit SHALL be decoded per REQ-021.

Verification (TICK_DIV=4, BLANK_CYCLES=2)
REQ-031 Reset release, enable=1 -> 2 clocks an=F, then an=4'b1110 for 4 clocks, 2 clocks dark, an=4'b1101 for 4 clocks, and so on; frame_done pulses every 24 clocks.
REQ-032 load 16'h1234 in IDLE -> load_ack one cycle; after enable, digit0 seg=7'h19, digit3 seg=7'h79.
REQ-033 load 16'hABCD mid-frame, then load_req held -> display unchanged until frame_done, second load_ack on the cycle after frame_done.
REQ-034 enable dropped during DRIVE idx=2 -> next clock an=F; re-enable restarts at idx=0 after 2 BLANK clocks.
REQ-035 display 16'h0070, macro defined -> digit3 and digit2 seg=7F, digit1 seg=78, digit0 seg=40; macro undefined -> digit3 and digit2 seg=40.
REQ-036 reset pulled low mid-DRIVE between clock edges -> an=F immediately; display reads 0000 after release.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: four-digit multiplexed 7-segment scan controller.
// Each digit is driven for TICK_DIV clocks. Between digits there is a dark gap of
// BLANK_CYCLES clocks. A one-deep shadow register takes new values. Those values
// reach the display register only at a frame boundary, or while idle, so a digit
// never shows half of an update.
// Optional build macro: LEADING_ZERO_BLANK_EN. When defined, leading zero digits
// 3..1 are shown dark.
module display_scan_ctrl #(
    parameter int TICK_DIV     = 25000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        load_req,
    input  logic [15:0] load_data,
    input  logic [3:0]  load_dp,
    output logic        load_ack,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    localparam logic [15:0] TICK_LAST  = 16'(TICK_DIV - 1);
    localparam logic [7:0]  BLANK_LAST = 8'(BLANK_CYCLES - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [1:0]  r_idx;
    logic [15:0] r_presc;
    logic [7:0]  r_blank_cnt;
    logic [15:0] r_disp;
    logic [3:0]  r_disp_dp;
    logic [15:0] r_shadow;
    logic [3:0]  r_shadow_dp;
    logic        r_pending;

    logic        w_tick;
    logic        w_blank_done;
    logic        w_frame_end;
    logic        w_transfer;
    logic        w_accept;
    logic [3:0]  w_nibble;
    logic [6:0]  w_digit_seg;

    // Hex nibble to active-low {g,f,e,d,c,b,a} segment pattern.
    function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            4'hF:    s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    assign w_tick       = (r_state == ST_DRIVE) && (r_presc == TICK_LAST);
    assign w_blank_done = (r_state == ST_BLANK) && (r_blank_cnt == BLANK_LAST);
    assign w_frame_end  = w_tick && (r_idx == 2'd3);
    // Shadow moves to the display only between frames, so a frame never tears.
    assign w_transfer   = r_pending && (w_frame_end || (r_state == ST_IDLE));
    // A transfer cycle still has pending set, so a coincident request waits a cycle.
    assign w_accept     = reset && load_req && !r_pending;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; dropping enable always returns to IDLE.
    always_comb begin
        w_next_state = r_state;
        if (!enable) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  w_next_state = ST_BLANK;
                ST_BLANK: w_next_state = w_blank_done ? ST_DRIVE : ST_BLANK;
                ST_DRIVE: w_next_state = w_tick ? ST_BLANK : ST_DRIVE;
                default:  w_next_state = ST_IDLE;
            endcase
        end
    end

    // Digit index, prescaler and blank counter; each one counts only in its own state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx       <= 2'd0;
            r_presc     <= 16'd0;
            r_blank_cnt <= 8'd0;
        end else if (!enable) begin
            r_idx       <= 2'd0;
            r_presc     <= 16'd0;
            r_blank_cnt <= 8'd0;
        end else begin
            case (r_state)
                ST_BLANK: begin
                    r_presc     <= 16'd0;
                    r_blank_cnt <= w_blank_done ? 8'd0 : r_blank_cnt + 8'd1;
                end
                ST_DRIVE: begin
                    r_blank_cnt <= 8'd0;
                    r_presc     <= w_tick ? 16'd0 : r_presc + 16'd1;
                    r_idx       <= w_tick ? r_idx + 2'd1 : r_idx;
                end
                default: begin
                    r_idx       <= 2'd0;
                    r_presc     <= 16'd0;
                    r_blank_cnt <= 8'd0;
                end
            endcase
        end
    end

    // Shadow capture on accept; the pending flag clears when the shadow is transferred.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shadow    <= 16'h0000;
            r_shadow_dp <= 4'h0;
            r_pending   <= 1'b0;
        end else if (w_accept) begin
            r_shadow    <= load_data;
            r_shadow_dp <= load_dp;
            r_pending   <= 1'b1;
        end else if (w_transfer) begin
            r_pending   <= 1'b0;
        end else begin
            r_pending   <= r_pending;
        end
    end

    // Display register; it is written only by a shadow transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_disp    <= 16'h0000;
            r_disp_dp <= 4'h0;
        end else if (w_transfer) begin
            r_disp    <= r_shadow;
            r_disp_dp <= r_shadow_dp;
        end else begin
            r_disp    <= r_disp;
            r_disp_dp <= r_disp_dp;
        end
    end

    // Select the current digit's nibble and decode it, blanking leading zeros if built in.
    always_comb begin
        w_nibble    = 4'h0;
        w_digit_seg = 7'h7F;
        case (r_idx)
            2'd0:    w_nibble = r_disp[3:0];
            2'd1:    w_nibble = r_disp[7:4];
            2'd2:    w_nibble = r_disp[11:8];
            2'd3:    w_nibble = r_disp[15:12];
            default: w_nibble = 4'h0;
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        case (r_idx)
            2'd3:    w_digit_seg = (r_disp[15:12] == 4'h0) ? 7'h7F : seg7_decode(w_nibble);
            2'd2:    w_digit_seg = (r_disp[15:8] == 8'h00) ? 7'h7F : seg7_decode(w_nibble);
            2'd1:    w_digit_seg = (r_disp[15:4] == 12'h000) ? 7'h7F : seg7_decode(w_nibble);
            default: w_digit_seg = seg7_decode(w_nibble);
        endcase
`else
        w_digit_seg = seg7_decode(w_nibble);
`endif
    end

    // Outputs decoded from state; async reset forces IDLE, which darkens anodes at once.
    always_comb begin
        an         = 4'hF;
        seg        = 7'h7F;
        dp         = 1'b1;
        frame_done = 1'b0;
        load_ack   = w_accept;
        case (r_state)
            ST_DRIVE: begin
                an         = ~(4'b0001 << r_idx);
                seg        = w_digit_seg;
                dp         = ~r_disp_dp[r_idx];
                frame_done = w_frame_end;
            end
            default: begin
                an         = 4'hF;
                seg        = 7'h7F;
                dp         = 1'b1;
                frame_done = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl with TICK_DIV=4 and BLANK_CYCLES=2.
// Each test pushes the digits it expects to a scoreboard. The monitor pops one entry
// each time the DUT starts driving a digit.
module tb_display_scan_ctrl;

    localparam int TD = 4;
    localparam int BC = 2;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        load_req;
    logic [15:0] load_data;
    logic [3:0]  load_dp;
    logic        load_ack;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t sb[$];

    logic [6:0] dec_tab [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    display_scan_ctrl #(.TICK_DIV(TD), .BLANK_CYCLES(BC)) dut (
        .clk(clk), .reset(reset), .enable(enable), .load_req(load_req),
        .load_data(load_data), .load_dp(load_dp), .load_ack(load_ack),
        .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_frame(input logic [15:0] d, input logic [3:0] p);
        exp_t e;
        logic [3:0] nib;
        for (int i = 0; i < 4; i++) begin
            nib     = d[i*4 +: 4];
            e.an    = 4'hF;
            e.an[i] = 1'b0;
            e.seg   = dec_tab[nib];
`ifdef LEADING_ZERO_BLANK_EN
            if (i > 0 && (d >> (i*4)) == 16'h0000) e.seg = 7'h7F;
`endif
            e.dp    = ~p[i];
            sb.push_back(e);
        end
    endtask

    // Wait through the dark gap, check one driven digit against the scoreboard, time it.
    task automatic observe_digit();
        int g;
        int len;
        int fd_n;
        bit fd_last;
        logic [3:0] a;
        exp_t e;
        g = 0;
        while (an === 4'hF && g < 100) begin
            @(negedge clk);
            g++;
        end
        total++;
        if (g >= 100) begin
            bad++;
            $display("FAIL wait_drive: no digit after %0d cycles", g);
            return;
        end
        total++;
        if (g !== BC) begin
            bad++;
            $display("FAIL dark_len: got %0d want %0d", g, BC);
        end
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL sb_empty: digit an=%h seen with no expectation", an);
            return;
        end
        e = sb.pop_front();
        total++;
        if (an !== e.an) begin
            bad++;
            $display("FAIL digit_an: got %h want %h", an, e.an);
        end
        total++;
        if (seg !== e.seg) begin
            bad++;
            $display("FAIL digit_seg (an=%h): got %h want %h", e.an, seg, e.seg);
        end
        total++;
        if (dp !== e.dp) begin
            bad++;
            $display("FAIL digit_dp (an=%h): got %b want %b", e.an, dp, e.dp);
        end
        a = an;
        len = 0;
        fd_n = 0;
        fd_last = 1'b0;
        while (an === a && len < 100) begin
            fd_last = (frame_done === 1'b1);
            if (fd_last) fd_n++;
            len++;
            @(negedge clk);
        end
        total++;
        if (len !== TD) begin
            bad++;
            $display("FAIL drive_len (an=%h): got %0d want %0d", e.an, len, TD);
        end
        total++;
        if (e.an == 4'b0111) begin
            if (fd_n !== 1 || !fd_last) begin
                bad++;
                $display("FAIL frame_done_d3: got count=%0d last=%0d want 1 1", fd_n, fd_last);
            end
        end else begin
            if (fd_n !== 0) begin
                bad++;
                $display("FAIL frame_done_other (an=%h): got count=%0d want 0", e.an, fd_n);
            end
        end
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        enable    = 1'b0;
        load_req  = 1'b1;
        load_data = 16'hFFFF;
        load_dp   = 4'hF;
        repeat (3) @(negedge clk);
        total++;
        if (an !== 4'hF) begin bad++; $display("FAIL rst_an: got %h want f", an); end
        total++;
        if (seg !== 7'h7F) begin bad++; $display("FAIL rst_seg: got %h want 7f", seg); end
        total++;
        if (dp !== 1'b1) begin bad++; $display("FAIL rst_dp: got %b want 1", dp); end
        total++;
        if (load_ack !== 1'b0) begin bad++; $display("FAIL rst_ack: got %b want 0", load_ack); end
        total++;
        if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_fd: got %b want 0", frame_done); end
        load_req = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load_idle();
        load_data = 16'h1234;
        load_dp   = 4'b0001;
        load_req  = 1'b1;
        #1;
        total++;
        if (load_ack !== 1'b1) begin bad++; $display("FAIL idle_ack: got %b want 1", load_ack); end
        push_frame(16'h1234, 4'b0001);
        push_frame(16'h1234, 4'b0001);
        @(negedge clk);
        total++;
        if (load_ack !== 1'b0) begin bad++; $display("FAIL idle_ack_pending: got %b want 0", load_ack); end
        load_req = 1'b0;
        enable   = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) observe_digit();
    endtask

    task automatic test_back_to_back();
        push_frame(16'h1234, 4'b0001);
        fork
            begin
                for (int i = 0; i < 12; i++) observe_digit();
            end
            begin
                int g;
                int stall_acks;
                g = 0;
                while (an !== 4'b1101 && g < 100) begin @(negedge clk); g++; end
                total++;
                if (g >= 100) begin bad++; $display("FAIL b2b_wait_d1: timeout %0d", g); end
                load_data = 16'hABCD;
                load_dp   = 4'b1010;
                load_req  = 1'b1;
                #1;
                total++;
                if (load_ack !== 1'b1) begin bad++; $display("FAIL b2b_ack1: got %b want 1", load_ack); end
                push_frame(16'hABCD, 4'b1010);
                @(negedge clk);
                load_data = 16'h5678;
                load_dp   = 4'b0101;
                stall_acks = 0;
                g = 0;
                while (frame_done !== 1'b1 && g < 100) begin
                    if (load_ack !== 1'b0) stall_acks++;
                    @(negedge clk);
                    g++;
                end
                total++;
                if (g >= 100) begin bad++; $display("FAIL b2b_wait_fd: timeout %0d", g); end
                total++;
                if (stall_acks !== 0) begin bad++; $display("FAIL b2b_stall_ack: got %0d acks want 0", stall_acks); end
                total++;
                if (load_ack !== 1'b0) begin bad++; $display("FAIL b2b_ack_at_fd: got %b want 0", load_ack); end
                @(negedge clk);
                total++;
                if (load_ack !== 1'b1) begin bad++; $display("FAIL b2b_ack2: got %b want 1", load_ack); end
                push_frame(16'h5678, 4'b0101);
                @(negedge clk);
                load_req = 1'b0;
            end
        join
    endtask

    task automatic test_enable_drop();
        int g;
        g = 0;
        while (an !== 4'b1011 && g < 100) begin @(negedge clk); g++; end
        total++;
        if (g >= 100) begin bad++; $display("FAIL drop_wait_d2: timeout %0d", g); end
        enable = 1'b0;
        @(negedge clk);
        total++;
        if (an !== 4'hF) begin bad++; $display("FAIL drop_an: got %h want f", an); end
        total++;
        if (seg !== 7'h7F) begin bad++; $display("FAIL drop_seg: got %h want 7f", seg); end
        repeat (2) @(negedge clk);
        push_frame(16'h5678, 4'b0101);
        enable = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) observe_digit();
    endtask

    task automatic test_reset_async();
        int g;
        g = 0;
        while (an !== 4'b1110 && g < 100) begin @(negedge clk); g++; end
        total++;
        if (g >= 100) begin bad++; $display("FAIL arst_wait_d0: timeout %0d", g); end
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (an !== 4'hF) begin bad++; $display("FAIL arst_an: got %h want f", an); end
        total++;
        if (seg !== 7'h7F) begin bad++; $display("FAIL arst_seg: got %h want 7f", seg); end
        @(negedge clk);
        push_frame(16'h0000, 4'b0000);
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) observe_digit();
    endtask

    task automatic test_lzb();
        enable = 1'b0;
        repeat (2) @(negedge clk);
        load_data = 16'h0070;
        load_dp   = 4'b0000;
        load_req  = 1'b1;
        #1;
        total++;
        if (load_ack !== 1'b1) begin bad++; $display("FAIL lzb_ack: got %b want 1", load_ack); end
        push_frame(16'h0070, 4'b0000);
        @(negedge clk);
        load_req = 1'b0;
        enable   = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) observe_digit();
    endtask

    initial begin
        test_reset();
        test_load_idle();
        test_back_to_back();
        test_enable_drop();
        test_reset_async();
        test_lzb();
        total++;
        if (sb.size() !== 0) begin bad++; $display("FAIL sb_leftover: got %0d want 0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
